// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - write-back queue serializing two producers onto one register file write port
module regfile_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int REG_ADDR_LEN = 5,
  parameter int REG_LENGTH   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aValid_i,
  input  logic [REG_ADDR_LEN-1:0]   aAddr_i,
  input  logic [REG_LENGTH-1:0]     aData_i,
  output logic                      aReady_o,
  input  logic                      bValid_i,
  input  logic [REG_ADDR_LEN-1:0]   bAddr_i,
  input  logic [REG_LENGTH-1:0]     bData_i,
  output logic                      bReady_o,
  output logic                      we_o,
  output logic [REG_ADDR_LEN-1:0]   wAddr_o,
  output logic [REG_LENGTH-1:0]     wData_o,
  input  logic [REG_ADDR_LEN-1:0]   qaAddr_i,
  input  logic [REG_ADDR_LEN-1:0]   qbAddr_i,
  output logic                      qaHit_o,
  output logic                      qbHit_o,
  output logic [REG_LENGTH-1:0]     qaData_o,
  output logic [REG_LENGTH-1:0]     qbData_o,
  output logic [$clog2(DEPTH):0]    pending_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_ADDR_LEN-1:0] addr_q [DEPTH];
  logic [REG_LENGTH-1:0]   data_q [DEPTH];
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           free;
  logic [PW-1:0]           slot_b;
  logic [PW-1:0]           look_idx;
  logic                    pop;
  logic                    acc_a;
  logic                    acc_b;

  // The register file never stalls, so any occupied head drains this cycle.
  assign pop  = (count_q != '0);
  assign free = CW'(DEPTH) - count_q + CW'(pop);

  // Port A owns the last free slot; B needs one more when A is also asking.
  assign aReady_o = rst_ni && (free >= CW'(1));
  assign bReady_o = rst_ni && (free >= (aValid_i ? CW'(2) : CW'(1)));

  // Writes to register 0 are swallowed: handshake completes but nothing is stored.
  assign acc_a  = aValid_i && aReady_o && (aAddr_i != '0);
  assign acc_b  = bValid_i && bReady_o && (bAddr_i != '0);
  assign slot_b = tail_q + PW'(acc_a);

  assign we_o      = pop;
  assign wAddr_o   = pop ? addr_q[head_q] : '0;
  assign wData_o   = pop ? data_q[head_q] : '0;
  assign pending_o = count_q;

  // Pointer and occupancy next-state; A lands older than B when both enqueue.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(acc_a) + PW'(acc_b);
    count_d = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop);
  end

  // Queue bookkeeping registers; reset drops every in-flight entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk_i) begin
    if (acc_a) begin
      addr_q[tail_q] <= aAddr_i;
      data_q[tail_q] <= aData_i;
    end
    if (acc_b) begin
      addr_q[slot_b] <= bAddr_i;
      data_q[slot_b] <= bData_i;
    end
  end

  // Bypass lookup: walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    qaHit_o  = 1'b0;
    qaData_o = '0;
    qbHit_o  = 1'b0;
    qbData_o = '0;
    look_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      look_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((qaAddr_i != '0) && (addr_q[look_idx] == qaAddr_i)) begin
          qaHit_o  = 1'b1;
          qaData_o = data_q[look_idx];
        end
        if ((qbAddr_i != '0) && (addr_q[look_idx] == qbAddr_i)) begin
          qbHit_o  = 1'b1;
          qbData_o = data_q[look_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr, qa_addr, qb_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, we, qa_hit, qb_hit;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data, qa_data, qb_data;
  logic [2:0]    pending;

  int checks = 0;
  int errors = 0;

  ent_t          mq[$];
  logic [DW-1:0] rf_mdl [32];
  logic [DW-1:0] rf_obs [32];

  regfile_wb_queue #(.DEPTH(DEPTH), .REG_ADDR_LEN(AW), .REG_LENGTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aValid_i(a_valid), .aAddr_i(a_addr), .aData_i(a_data), .aReady_o(a_ready),
    .bValid_i(b_valid), .bAddr_i(b_addr), .bData_i(b_data), .bReady_o(b_ready),
    .we_o(we), .wAddr_o(w_addr), .wData_o(w_data),
    .qaAddr_i(qa_addr), .qbAddr_i(qb_addr),
    .qaHit_o(qa_hit), .qbHit_o(qb_hit), .qaData_o(qa_data), .qbData_o(qb_data),
    .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for an address, straight from the ordered list of entries.
  function automatic void lookup(input logic [AW-1:0] q, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (q != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == q) begin
          h = 1'b1;
          d = mq[i].d;
          break;
        end
      end
    end
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks, advances the model.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic [AW-1:0] qa, input logic [AW-1:0] qb,
                      output logic acc_a, output logic acc_b);
    ent_t          e;
    int            free;
    logic          ew, ea, eb, eh, ow;
    logic [AW-1:0] eaddr, oa;
    logic [DW-1:0] edat, ewd, od;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    qa_addr = qa; qb_addr = qb;
    #1;
    ew    = (mq.size() != 0);
    eaddr = '0;
    ewd   = '0;
    if (ew) begin
      eaddr = mq[0].a;
      ewd   = mq[0].d;
    end
    check("we", we, ew);
    check("wAddr", w_addr, eaddr);
    check("wData", w_data, ewd);
    check("pending", pending, mq.size());
    free = DEPTH - mq.size() + (ew ? 1 : 0);
    ea   = (free >= 1);
    eb   = (free >= (av ? 2 : 1));
    check("aReady", a_ready, ea);
    check("bReady", b_ready, eb);
    lookup(qa, eh, edat);
    check("qaHit", qa_hit, eh);
    check("qaData", qa_data, edat);
    lookup(qb, eh, edat);
    check("qbHit", qb_hit, eh);
    check("qbData", qb_data, edat);
    ow = we; oa = w_addr; od = w_data;
    acc_a = av && ea;
    acc_b = bv && eb;
    @(posedge clk);
    if (ow) rf_obs[oa] = od;
    if (ew) begin
      rf_mdl[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (acc_a && aa != '0) begin e.a = aa; e.d = ad; mq.push_back(e); end
    if (acc_b && ba != '0) begin e.a = ba; e.d = bd; mq.push_back(e); end
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] qa, input logic [AW-1:0] qb);
    logic x, y;
    step(1'b0, '0, '0, 1'b0, '0, '0, qa, qb, x, y);
  endtask

  initial begin
    logic ra, rb;
    int   next, guard;
    for (int i = 0; i < 32; i++) begin
      rf_mdl[i] = '0;
      rf_obs[i] = '0;
    end
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hdead;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'hbeef;
    qa_addr = 5'd5; qb_addr = 5'd6;
    #12;
    check("rst_we", we, 1'b0);
    check("rst_wAddr", w_addr, '0);
    check("rst_wData", w_data, '0);
    check("rst_pending", pending, 3'd0);
    check("rst_aReady", a_ready, 1'b0);
    check("rst_bReady", b_ready, 1'b0);
    check("rst_qaHit", qa_hit, 1'b0);
    check("rst_qbData", qb_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write with lookup before, during and after the drain cycle.
    step(1'b1, 5'd5, 32'h0000_1234, 1'b0, '0, '0, 5'd5, '0, ra, rb);
    check("single_acc", ra, 1'b1);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);
    check("single_rf", rf_obs[5], 32'h0000_1234);

    // Same address from both ports: B is younger and wins.
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, ra, rb);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);
    check("dup_rf", rf_obs[7], 32'h2);

    // Backpressure with distinct addresses 1..12 offered on both ports every cycle.
    next  = 1;
    guard = 0;
    while (next <= 12 && guard < 50) begin
      step(1'b1, AW'(next), DW'($urandom), (next + 1 <= 12), AW'(next + 1), DW'($urandom),
           AW'(next - 1), AW'(next - 2), ra, rb);
      next += (ra ? 1 : 0) + ((ra && rb && next + 1 <= 12) ? 1 : 0);
      guard++;
    end
    check("bp_done", next, 13);
    for (int i = 0; i < 6; i++) idle(5'd12, 5'd11);

    // Writes to register 0 are accepted and dropped.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 5'd0, 5'd0, ra, rb);
    check("zero_acc", ra, 1'b1);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Sequential single-port writes with idle gaps walk the pointers around twice.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0)
        step(1'b1, AW'(k + 20), DW'($urandom), 1'b0, '0, '0, AW'(k + 20), AW'(k + 19), ra, rb);
      else
        step(1'b0, '0, '0, 1'b1, AW'(k + 20), DW'($urandom), AW'(k + 20), AW'(k + 19), ra, rb);
      idle(AW'(k + 20), AW'(k + 19));
    end

    // Random traffic over a small address range to exercise duplicates and zero.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ra, rb);
    end
    for (int i = 0; i < 6; i++) idle(5'd1, 5'd2);

    // Asynchronous reset in the middle of a drain with three entries pending.
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd9, 5'd10, ra, rb);
    step(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 5'd11, 5'd12, ra, rb);
    check("pre_rst_pending", pending, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", we, 1'b0);
    check("arst_pending", pending, 3'd0);
    check("arst_qaHit", qa_hit, 1'b0);
    check("arst_qbHit", qb_hit, 1'b0);
    check("arst_aReady", a_ready, 1'b0);
    mq.delete();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    check("arst_edge_we", we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle(5'd11, 5'd12);

    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), rf_obs[i], rf_mdl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
